// File: rtl/riscv_instr_line_responder.sv
// Instruction line-fetch responder: reads BEATS words from a 1-cycle sync SRAM and returns one line per rvalid.
// Optional line-hit path (stored-line reuse) enabled by defining RISCV_INSTR_RESP_LINE_HIT_EN.
`default_nettype none

module riscv_instr_line_responder #(
  parameter int RDATA_OUT_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_req_i,
  input  logic [31:0]                instr_addr_i,
  output logic                       instr_gnt_o,
  output logic                       instr_rvalid_o,
  output logic [RDATA_OUT_WIDTH-1:0] instr_rdata_o,
  input  logic                       flush_i,
  output logic                       mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [31:0]                mem_rdata_i,
  output logic                       busy_o
);

  localparam int BEATS = RDATA_OUT_WIDTH / 32;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = MEM_ADDR_WIDTH - BW;

`ifdef RISCV_INSTR_RESP_LINE_HIT_EN
  typedef enum logic [1:0] {IDLE, READ, LAST, HIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, LAST} state_t;
`endif

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q;
  logic [LW-1:0]              line_q;
  logic [LW-1:0]              req_line;
  logic [31:0]                word_q [BEATS-1];
  logic [RDATA_OUT_WIDTH-1:0] line_cur;
  logic [RDATA_OUT_WIDTH-1:0] line_out_q;
  logic                       accept;
  logic                       hit;
  logic                       deliver;

  assign req_line = instr_addr_i[MEM_ADDR_WIDTH+1 -: LW];

`ifdef RISCV_INSTR_RESP_LINE_HIT_EN
  logic [LW-1:0] tag_q;
  logic          tag_vld_q;
  logic [LW-1:0] tag_cmp;
  logic          tag_cmp_vld;

  // In LAST the line being delivered is the one out_q will hold next cycle, so compare against it.
  assign tag_cmp     = (state_q == LAST) ? line_q : tag_q;
  assign tag_cmp_vld = (state_q == LAST) ? 1'b1 : tag_vld_q;
  assign hit         = tag_cmp_vld & (req_line == tag_cmp) & ~flush_i;
  assign accept      = (state_q == IDLE) | (state_q == LAST) | (state_q == HIT);
  assign deliver     = (state_q == LAST) | (state_q == HIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= 1'b0;
    end else if (flush_i) begin
      tag_vld_q <= 1'b0;
    end else if (state_q == LAST) begin
      tag_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LAST) tag_q <= line_q;
  end

  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[31:MEM_ADDR_WIDTH+2], instr_addr_i[BW+1:0]};
`else
  assign hit     = 1'b0;
  assign accept  = (state_q == IDLE) | (state_q == LAST);
  assign deliver = (state_q == LAST);

  logic unused_in;
  assign unused_in = ^{instr_addr_i[31:MEM_ADDR_WIDTH+2], instr_addr_i[BW+1:0], flush_i};
`endif

  assign instr_gnt_o    = instr_req_i & accept & ~rst;
  assign instr_rvalid_o = deliver & ~rst;
  assign mem_req_o      = (state_q == READ) & ~rst;
  assign mem_addr_o     = mem_req_o ? {line_q, beat_q} : '0;
  assign busy_o         = (state_q != IDLE);

  // The top word arrives in LAST and is bypassed straight onto the line.
  always_comb begin
    line_cur = '0;
    for (int i = 0; i < BEATS - 1; i++) begin
      line_cur[32*i +: 32] = word_q[i];
    end
    line_cur[RDATA_OUT_WIDTH-1 -: 32] = mem_rdata_i;
  end

  assign instr_rdata_o = (state_q == LAST) ? line_cur : line_out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      READ: begin
        if (beat_q == BW'(BEATS - 1)) state_d = LAST;
      end
      default: begin
        if (instr_gnt_o) begin
`ifdef RISCV_INSTR_RESP_LINE_HIT_EN
          state_d = hit ? HIT : READ;
`else
          state_d = READ;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == READ) beat_q <= beat_q + BW'(1);
      if (state_q == LAST) line_out_q <= line_cur;
    end
  end

  // Line address and returned words: data path, no reset.
  always_ff @(posedge clk) begin
    if (instr_gnt_o) line_q <= req_line;
    if ((state_q == READ) && (beat_q != '0)) word_q[beat_q - BW'(1)] <= mem_rdata_i;
  end

  logic unused_hit;
  assign unused_hit = hit;

endmodule

`default_nettype wire

// File: tb/tb_riscv_instr_line_responder.sv
// Directed + randomized bench for riscv_instr_line_responder (default build, 128-bit line, 12-bit word address).
`default_nettype none

module tb_riscv_instr_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_req_i;
  logic [31:0]  instr_addr_i;
  logic         instr_gnt_o;
  logic         instr_rvalid_o;
  logic [127:0] instr_rdata_o;
  logic         flush_i;
  logic         mem_req_o;
  logic [11:0]  mem_addr_o;
  logic [31:0]  mem_rdata_i;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mem [4096];
  logic [127:0] last_line;

  riscv_instr_line_responder #(.RDATA_OUT_WIDTH(128), .MEM_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM with one-cycle read latency; junk on idle cycles.
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
    else           mem_rdata_i <= $urandom;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line = 4 consecutive words starting at the line-aligned word address, modulo memory size.
  function automatic logic [127:0] ref_line(input logic [31:0] a);
    int base;
    logic [127:0] r;
    base = ((a / 16) % 1024) * 4;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = mem[(base + i) % 4096];
    return r;
  endfunction

  function automatic logic [11:0] ref_waddr(input logic [31:0] a, input int k);
    return 12'((((a / 16) % 1024) * 4 + k) % 4096);
  endfunction

  // Called positioned just after a negedge; grant is expected in this cycle.
  task automatic fetch(input logic [31:0] a, input bit chain, input logic [31:0] nxt);
    logic [127:0] exp;
    instr_req_i  = 1'b1;
    instr_addr_i = a;
    #1;
    chk("gnt", 128'(instr_gnt_o), 128'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instr_req_i  = chain;
      instr_addr_i = chain ? nxt : $urandom;
      #1;
      chk("mem_req", 128'(mem_req_o), 128'(1));
      chk("mem_addr", 128'(mem_addr_o), 128'(ref_waddr(a, k)));
      chk("no_rvalid", 128'(instr_rvalid_o), 128'(0));
      chk("no_gnt_read", 128'(instr_gnt_o), 128'(0));
      chk("busy", 128'(busy_o), 128'(1));
      chk("rdata_hold", instr_rdata_o, last_line);
    end
    @(negedge clk);
    #1;
    exp = ref_line(a);
    chk("rvalid", 128'(instr_rvalid_o), 128'(1));
    chk("rdata", instr_rdata_o, exp);
    chk("mem_req_last", 128'(mem_req_o), 128'(0));
    chk("gnt_last", 128'(instr_gnt_o), 128'(chain));
    last_line = exp;
  endtask

  task automatic idle_check();
    @(negedge clk);
    instr_req_i = 1'b0;
    #1;
    chk("idle_rvalid", 128'(instr_rvalid_o), 128'(0));
    chk("idle_busy", 128'(busy_o), 128'(0));
    chk("idle_rdata", instr_rdata_o, last_line);
  endtask

  initial begin
    logic [31:0] a, nxt;
    bit ch;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) mem[32'h40 + i] = 32'hA0 + 32'(i);
    last_line    = '0;
    rst          = 1'b1;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h100;
    flush_i      = 1'b0;

    // Reset state, with a request pending that must not be granted.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt", 128'(instr_gnt_o), 128'(0));
    chk("rst_rvalid", 128'(instr_rvalid_o), 128'(0));
    chk("rst_mem_req", 128'(mem_req_o), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_rdata", instr_rdata_o, 128'(0));
    instr_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, then back-to-back 0x100 -> 0x110.
    fetch(32'h100, 1'b0, 32'h0);
    chk("single_const", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
    idle_check();
    fetch(32'h100, 1'b1, 32'h110);
    fetch(32'h110, 1'b0, 32'h0);
    chk("b2b_const", last_line, 128'h000000A7_000000A6_000000A5_000000A4);
    idle_check();

    // Reset asserted three cycles after grant aborts the line.
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h300;
    #1;
    chk("abort_gnt", 128'(instr_gnt_o), 128'(1));
    @(negedge clk);
    instr_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rvalid", 128'(instr_rvalid_o), 128'(0));
    chk("abort_gnt0", 128'(instr_gnt_o), 128'(0));
    chk("abort_mem_req", 128'(mem_req_o), 128'(0));
    chk("abort_busy", 128'(busy_o), 128'(0));
    last_line = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rvalid", 128'(instr_rvalid_o), 128'(0));
    end
    fetch(32'h300, 1'b0, 32'h0);
    idle_check();

    // Address wrap at the top of the memory.
    fetch(32'hFFF0, 1'b1, 32'h4000);
    fetch(32'h4000, 1'b0, 32'h0);
    idle_check();

    // Same line twice with no line-hit feature: both go to memory.
    fetch(32'h200, 1'b0, 32'h0);
    idle_check();
    flush_i = 1'b1;
    fetch(32'h20C, 1'b0, 32'h0);
    flush_i = 1'b0;
    idle_check();

    // Randomized fetches, some chained back-to-back.
    nxt = $urandom;
    for (int n = 0; n < 10; n++) begin
      a   = nxt;
      nxt = $urandom;
      ch  = (n < 9) && ($urandom_range(0, 1) == 1);
      fetch(a, ch, nxt);
      if (!ch) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
